// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Optional flag logic is selected by PIPE_ADDER_FLAGS_EN.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic bit split_ok(
    input int width,
    input int stages
  );
    return (stages > 0) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered S-bit slice of the pipelined adder.
// Carries operands forward and accumulates the finished low sum bits.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int S     = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             up_valid,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_acc,
  output logic             valid,
  output logic             carry,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] next_acc,
  output logic             next_carry
);

  logic [S:0] part;

  // Add this stage's slice with the carry from the previous stage.
  always_comb begin
    part = {1'b0, up_a[K*S +: S]}
         + {1'b0, up_b[K*S +: S]}
         + {{S{1'b0}}, up_carry};
  end

  // Merge the new slice into the partial sum passed down the pipe.
  always_comb begin
    next_acc = up_acc;
    next_acc[K*S +: S] = part[S-1:0];
  end

  assign next_carry = part[S];

  // Stage registers move only on the global advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
    end else if (adv) begin
      valid <= up_valid;
      carry <= part[S];
      opa   <= up_a;
      opb   <= up_b;
      acc   <= next_acc;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub, one slice per stage, valid/ready on both sides.
// Define PIPE_ADDER_FLAGS_EN to build the cout/ovf/zero flag registers.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic             sub;
  logic [STAGES:0]  v;
  logic [STAGES:0]  c;
  logic [WIDTH-1:0] a  [STAGES+1];
  logic [WIDTH-1:0] b  [STAGES+1];
  logic [WIDTH-1:0] s  [STAGES+1];
  logic [WIDTH-1:0] sd [STAGES];
  logic [STAGES-1:0] cd;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign sub      = (op_e'(op) == OP_SUB);

  assign v[0] = in_valid;
  assign c[0] = sub ? 1'b1 : cin;
  assign a[0] = add_in1;
  assign b[0] = sub ? ~add_in2 : add_in2;
  assign s[0] = '0;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    adder_slice #(
      .WIDTH (WIDTH),
      .S     (S),
      .K     (g)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (adv),
      .up_valid   (v[g]),
      .up_carry   (c[g]),
      .up_a       (a[g]),
      .up_b       (b[g]),
      .up_acc     (s[g]),
      .valid      (v[g+1]),
      .carry      (c[g+1]),
      .opa        (a[g+1]),
      .opb        (b[g+1]),
      .acc        (s[g+1]),
      .next_acc   (sd[g]),
      .next_carry (cd[g])
    );
  end

  assign out_valid = v[STAGES];
  assign sum       = s[STAGES];

`ifdef PIPE_ADDER_FLAGS_EN
  flags_t flags_d;
  flags_t flags_q;

  // Flags come from the last slice's result and the operand sign bits.
  always_comb begin
    flags_d.cout = cd[L];
    flags_d.ovf  = (a[L][WIDTH-1] == b[L][WIDTH-1])
                && (sd[L][WIDTH-1] != a[L][WIDTH-1]);
    flags_d.zero = (sd[L] == '0);
  end

  // Flags register in step with the final sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (adv) begin
      flags_q <= flags_d;
    end
  end

  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;
`else
  assign cout = 1'b0;
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

  logic unused_bits;

  // Leftover stage outputs that the result path does not consume.
  always_comb begin
    unused_bits = c[STAGES] ^ (^a[STAGES]) ^ (^b[STAGES]);
    for (int k = 0; k < STAGES; k++) begin
      unused_bits = unused_bits ^ (^sd[k]) ^ cd[k];
    end
  end

endmodule
